delay_sched: RTL and testbench

DELAY_SCHED -- requirements
Module: delay_sched

---
 rtl/delay_sched.sv | 119 +++++++++++
 tb/tb_delay_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_sched.sv
// Round-robin scheduler sharing one prescaler/down-counter among four requesters.
// The owner is granted, counts its latched delay in prescaler ticks, then gets a one-cycle done pulse.
module delay_sched #(
  parameter int DIV_BITS = 22,
  parameter int DW       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [4*DW-1:0]  dly,
  output logic [3:0]       grant,
  output logic [3:0]       done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          grant_q, grant_d;
  logic [3:0]          done_q, done_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [DW-1:0]       rem_q, rem_d;
  logic [DIV_BITS-1:0] presc_q, presc_d;

  logic [1:0]          win;
  logic [1:0]          idx;
  logic [DW-1:0]       dly_w;
  logic                tick;
  logic                owner_req;

  // Scan ptr+3 down to ptr+1 so the nearest pending requester after ptr wins; ptr itself is last resort.
  always_comb begin
    win = ptr_q;
    idx = ptr_q;
    for (int k = 3; k >= 1; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    unique case (win)
      2'd0:    dly_w = dly[0*DW +: DW];
      2'd1:    dly_w = dly[1*DW +: DW];
      2'd2:    dly_w = dly[2*DW +: DW];
      default: dly_w = dly[3*DW +: DW];
    endcase
  end

  assign tick      = (presc_q == {DIV_BITS{1'b1}});
  assign owner_req = |(req & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        presc_d = '0;
        if (req != 4'b0000) begin
          grant_d = 4'b0001 << win;
          ptr_d   = win;
          rem_d   = dly_w;
          if (dly_w == '0) begin
            state_d = DONE;
            done_d  = 4'b0001 << win;
          end else begin
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        presc_d = presc_q + 1'b1;
        // Abort wins over a coincident final tick: a dropped request never sees done.
        if (!owner_req) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (tick) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == {{(DW-1){1'b0}}, 1'b1}) begin
            state_d = DONE;
            done_d  = grant_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      ptr_q   <= 2'd3;
      rem_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_delay_sched.sv
// Bench for delay_sched: directed scenarios plus random traffic, checked every cycle against
// a cycle-countdown model of owner, remaining cycles and round-robin pointer.
module tb_delay_sched;

  localparam int DIV_BITS = 2;
  localparam int DW       = 8;
  localparam int P        = 1 << DIV_BITS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = 4'b0000;
  logic [7:0]    d [4];
  logic [4*DW-1:0] dly;
  logic [3:0]    grant, done;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  // model state
  int m_owner = -1;
  int m_left  = 0;
  int m_ptr   = 3;
  bit m_done  = 1'b0;

  assign dly = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  delay_sched #(.DIV_BITS(DIV_BITS), .DW(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .dly   (dly),
    .grant (grant),
    .done  (done),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference behaviour, from the inputs present at that edge.
  task automatic model_edge();
    int c;
    bit found;
    if (rst) begin
      m_owner = -1;
      m_done  = 1'b0;
      m_ptr   = 3;
    end else if (m_owner < 0) begin
      if (req != 4'b0000) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          c = (m_ptr + k) % 4;
          if (!found && req[c]) begin
            found   = 1'b1;
            m_owner = c;
          end
        end
        m_ptr  = m_owner;
        m_left = int'(d[m_owner]) * P;
        m_done = (m_left == 0);
      end
    end else if (m_done) begin
      m_owner = -1;
      m_done  = 1'b0;
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end
  endtask

  task automatic cyc();
    logic [3:0] eg, ed;
    @(posedge clk);
    model_edge();
    #1;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    ed = m_done ? eg : 4'b0000;
    chk("model_grant", 32'(grant), 32'(eg));
    chk("model_done",  32'(done),  32'(ed));
    chk("model_busy",  32'(busy),  32'(m_owner >= 0));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) d[i] = 8'd0;

    // reset state
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done",  32'(done),  32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    rst = 1'b0;
    cyc();

    // single request, dly0=3
    req = 4'b0001; d[0] = 8'd3;
    cyc();
    chk("single_grant_t1", 32'(grant), 32'h1);
    repeat (11) cyc();
    chk("single_nodone_t12", 32'(done), 32'h0);
    cyc();
    chk("single_done_t13", 32'(done), 32'h1);
    chk("single_grant_t13", 32'(grant), 32'h1);
    req = 4'b0000;
    cyc();
    chk("single_grant_t14", 32'(grant), 32'h0);
    chk("single_busy_t14",  32'(busy),  32'h0);

    // zero delay
    req = 4'b0100; d[2] = 8'd0;
    cyc();
    chk("zero_grant", 32'(grant), 32'h4);
    chk("zero_done",  32'(done),  32'h4);
    req = 4'b0000;
    cyc();
    chk("zero_idle_grant", 32'(grant), 32'h0);
    chk("zero_idle_busy",  32'(busy),  32'h0);

    // round robin, all requesters held, dly=1
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 8'd1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_grant", 32'(grant), 32'(1 << (k % 4)));
      repeat (3) cyc();
      chk("rr_nodone", 32'(done), 32'h0);
      cyc();
      chk("rr_done", 32'(done), 32'(1 << (k % 4)));
      if (k == 4) req = 4'b0000;
      cyc();
      chk("rr_gap_grant", 32'(grant), 32'h0);
    end

    // abort
    req = 4'b0010; d[1] = 8'd5;
    cyc();
    chk("abort_grant", 32'(grant), 32'h2);
    repeat (6) cyc();
    req = 4'b0000;
    cyc();
    chk("abort_grant_off", 32'(grant), 32'h0);
    chk("abort_no_done",   32'(done),  32'h0);
    d[0] = 8'd1; d[1] = 8'd1;
    req = 4'b0011;
    cyc();
    chk("abort_next_grant0", 32'(grant), 32'h1);
    repeat (3) cyc();
    cyc();
    chk("abort_done0", 32'(done), 32'h1);
    cyc();
    cyc();
    chk("abort_next_grant1", 32'(grant), 32'h2);
    req = 4'b0000;
    repeat (6) cyc();

    // reset during COUNT
    req = 4'b0100; d[2] = 8'd5;
    cyc();
    chk("rstmid_grant", 32'(grant), 32'h4);
    repeat (3) cyc();
    rst = 1'b1; req = 4'b0000;
    cyc();
    chk("rstmid_grant0", 32'(grant), 32'h0);
    chk("rstmid_done0",  32'(done),  32'h0);
    chk("rstmid_busy0",  32'(busy),  32'h0);
    rst = 1'b0;
    cyc();
    chk("rstmid_nodone", 32'(done), 32'h0);
    req = 4'b1001;
    cyc();
    chk("rstmid_regrant", 32'(grant), 32'h1);
    req = 4'b0000;
    repeat (3) cyc();

    // maximum delay honoured in full
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 4'b0001; d[0] = 8'hFF;
    cyc();
    chk("max_grant", 32'(grant), 32'h1);
    repeat (1019) cyc();
    chk("max_nodone_early", 32'(done), 32'h0);
    cyc();
    chk("max_done", 32'(done), 32'h1);
    req = 4'b0000;
    cyc();

    // random traffic including dly changes while busy and occasional resets
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 2) == 0) d[$urandom_range(0, 3)] = 8'($urandom_range(0, 3));
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0; req = 4'b0000;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
